// File: rtl/systolic_array.sv
// systolic_array: output-stationary NxN unsigned MAC grid computing one C = A*B block per start.
// Define SYSTOLIC_SAT_EN to saturate each C element instead of keeping its low BIT_W bits.
module systolic_array #(
    parameter int N     = 2,
    parameter int BIT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N*N*BIT_W-1:0]   a_flat,
    input  logic [N*N*BIT_W-1:0]   b_flat,
    output logic [N*N*BIT_W-1:0]   c_flat,
    output logic                   busy,
    output logic                   done
);
    localparam int AW = 2*BIT_W + $clog2(N);
    localparam int SW = $clog2(3*N-2);
    localparam logic [SW-1:0] LAST = SW'(3*N-3);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [SW-1:0] step;
    logic [N*N*BIT_W-1:0] a_buf, b_buf;
    logic [BIT_W-1:0] left [N];
    logic [BIT_W-1:0] top [N];
    logic [BIT_W-1:0] a_in [N][N];
    logic [BIT_W-1:0] b_in [N][N];
    logic [BIT_W-1:0] a_reg [N][N];
    logic [BIT_W-1:0] b_reg [N][N];
    logic [2*BIT_W-1:0] prod [N][N];
    logic [AW-1:0] acc [N][N];
    logic accept;
    assign accept = state == IDLE && start;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            a_buf <= '0;
            b_buf <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= state_n != IDLE;
            done  <= state_n == DONE;
            step  <= (state == RUN) ? step + 1'b1 : '0;
            if (accept) begin
                a_buf <= a_flat;
                b_buf <= b_flat;
            end
        end
    end
    always_comb begin
        state_n = (state == IDLE) ? (start ? RUN : IDLE) :
                  (state == RUN)  ? ((step == LAST) ? DONE : RUN) : IDLE;
    end
    // Edge skew: row i of A and column i of B enter i steps late, zero outside their window.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            left[i] = '0;
            top[i]  = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(step) == k + i) begin
                    left[i] = a_buf[(i*N+k)*BIT_W +: BIT_W];
                    top[i]  = b_buf[(k*N+i)*BIT_W +: BIT_W];
                end
            end
        end
    end
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [BIT_W-1:0] c_el;
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = left[i];
            end else begin : g_a_hop
                assign a_in[i][j] = a_reg[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = top[j];
            end else begin : g_b_hop
                assign b_in[i][j] = b_reg[i-1][j];
            end
            assign prod[i][j] = {{BIT_W{1'b0}}, a_in[i][j]} * {{BIT_W{1'b0}}, b_in[i][j]};
`ifdef SYSTOLIC_SAT_EN
            assign c_el = (|acc[i][j][AW-1:BIT_W]) ? {BIT_W{1'b1}} : acc[i][j][BIT_W-1:0];
`else
            assign c_el = acc[i][j][BIT_W-1:0];
`endif
            assign c_flat[(i*N+j)*BIT_W +: BIT_W] = (state == RUN) ? '0 : c_el;
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst || accept) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end else if (state == RUN) begin
                    a_reg[i][j] <= a_in[i][j];
                    b_reg[i][j] <= b_in[i][j];
                    acc[i][j]   <= acc[i][j] + AW'(prod[i][j]);
                end
            end
        end
    end
endmodule
